// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: LFSR hole pick, timed mole window, hit/miss judging
// and a saturating two-digit BCD score.
module mole_round_ctrl #(
  parameter int unsigned NUM_HOLES = 9,
  parameter logic [31:0] MOLE_TIME = 32'd100000000,
  parameter logic [31:0] GAP_TIME  = 32'd25000000,
  parameter logic [7:0]  ROUNDS    = 8'd20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 cin,
  input  logic                 KEY0,
  input  logic                 start_n,
  input  logic [NUM_HOLES-1:0] sw,
  output logic [NUM_HOLES-1:0] led,
  output logic [3:0]           score_ones,
  output logic [3:0]           score_tens,
  output logic [7:0]           round_num,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);

  localparam int unsigned IW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic [1:0]           state;
  logic [31:0]          timer;
  logic [15:0]          lfsr;
  logic [NUM_HOLES-1:0] sw_s1, sw_s2, sw_s3;
  logic                 st_s1, st_s2, st_s3;
  logic [NUM_HOLES-1:0] sw_evt;
  logic                 start_evt;
  logic [IW-1:0]        raw_idx, pick_idx, cur_idx, prev_idx;
  logic                 hit, timeout;
  logic [7:0]           round_next;

  // Third flop holds the previous synchronized level so a press is a single-cycle event.
  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      sw_s3 <= '0;
      st_s1 <= 1'b0;
      st_s2 <= 1'b0;
      st_s3 <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      sw_s3 <= sw_s2;
      st_s1 <= ~start_n;
      st_s2 <= st_s1;
      st_s3 <= st_s2;
    end
  end

  assign sw_evt    = sw_s2 & ~sw_s3;
  assign start_evt = st_s2 & ~st_s3;

  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    raw_idx  = IW'(lfsr % 16'(NUM_HOLES));
    pick_idx = raw_idx;
    if (raw_idx == prev_idx)
      pick_idx = (raw_idx == IW'(NUM_HOLES - 1)) ? '0 : raw_idx + IW'(1);
  end

  assign hit        = sw_evt[cur_idx];
  assign timeout    = (timer == MOLE_TIME - 32'd1);
  assign round_next = round_num + 8'd1;
  assign game_over  = (state == S_OVER);

  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      state      <= S_IDLE;
      timer      <= '0;
      led        <= '0;
      score_ones <= '0;
      score_tens <= '0;
      round_num  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      cur_idx    <= '0;
      prev_idx   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          led <= '0;
          if (start_evt) begin
            score_ones <= '0;
            score_tens <= '0;
            round_num  <= '0;
            timer      <= '0;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer == GAP_TIME - 32'd1) begin
            cur_idx  <= pick_idx;
            prev_idx <= pick_idx;
            led      <= NUM_HOLES'(1) << pick_idx;
            timer    <= '0;
            state    <= S_UP;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          // Hit is tested first so a press landing on the final window cycle still scores.
          if (hit || timeout) begin
            led <= '0;
            if (hit) begin
              hit_pulse <= 1'b1;
              if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
                if (score_ones == 4'd9) begin
                  score_ones <= '0;
                  score_tens <= score_tens + 4'd1;
                end else begin
                  score_ones <= score_ones + 4'd1;
                end
              end
            end else begin
              miss_pulse <= 1'b1;
            end
            round_num <= round_next;
            timer     <= '0;
            state     <= (round_next == ROUNDS) ? S_OVER : S_GAP;
          end else begin
            timer <= timer + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized bench for mole_round_ctrl against a deadline-based game model, plus a
// second instance with a long game used to drive the score through 09->10 and 99.
module tb_mole_round_ctrl;

  localparam int NH = 9;
  localparam int M  = 8;
  localparam int G  = 4;
  localparam int R  = 3;
  localparam int PH_IDLE = 0, PH_GAP = 1, PH_UP = 2, PH_OVER = 3;

  logic          clk = 1'b0;
  logic          rst_n, start_n, start2_n;
  logic [NH-1:0] sw, sw2, led, led2;
  logic [3:0]    score_ones, score_tens, ones2, tens2;
  logic [7:0]    round_num, round2;
  logic          hit_pulse, miss_pulse, game_over, hit2, miss2, over2;

  always #5 clk = ~clk;

  mole_round_ctrl #(
    .NUM_HOLES(NH), .MOLE_TIME(32'(M)), .GAP_TIME(32'(G)),
    .ROUNDS(8'(R)), .LFSR_SEED(16'hACE1)
  ) dut (
    .cin(clk), .KEY0(rst_n), .start_n(start_n), .sw(sw), .led(led),
    .score_ones(score_ones), .score_tens(score_tens), .round_num(round_num),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  mole_round_ctrl #(
    .NUM_HOLES(NH), .MOLE_TIME(32'(M)), .GAP_TIME(32'(G)),
    .ROUNDS(8'd255), .LFSR_SEED(16'hACE1)
  ) dut_long (
    .cin(clk), .KEY0(rst_n), .start_n(start2_n), .sw(sw2), .led(led2),
    .score_ones(ones2), .score_tens(tens2), .round_num(round2),
    .hit_pulse(hit2), .miss_pulse(miss2), .game_over(over2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase plus absolute cycle deadlines, integer score.
  int            cyc, ph, score, rnd, mole, prv, deadline;
  logic [15:0]   lf;
  logic [NH-1:0] h1, h2, h3;
  logic          s1, s2, s3;
  logic          x_hit, x_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; score = 0; rnd = 0; mole = 0; prv = 0; deadline = 0;
    lf = 16'hACE1; h1 = '0; h2 = '0; h3 = '0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    x_hit = 1'b0; x_miss = 1'b0;
  endtask

  // A pin level first sampled at edge k becomes an event consumed at edge k+2.
  task automatic model_step();
    logic [NH-1:0] ev;
    logic          sev;
    int            cand;
    cyc++;
    ev  = h2 & ~h3;
    sev = s2 & ~s3;
    x_hit = 1'b0; x_miss = 1'b0;
    cand = int'(lf % 16'(NH));
    if (cand == prv) cand = (cand + 1) % NH;
    case (ph)
      PH_IDLE, PH_OVER:
        if (sev) begin score = 0; rnd = 0; ph = PH_GAP; deadline = cyc + G; end
      PH_GAP:
        if (cyc == deadline) begin mole = cand; prv = cand; ph = PH_UP; deadline = cyc + M; end
      default: begin
        if (ev[4'(mole)]) begin x_hit = 1'b1; if (score < 99) score++; end
        else if (cyc == deadline) x_miss = 1'b1;
        if (x_hit || x_miss) begin
          rnd++;
          if (rnd == R) ph = PH_OVER;
          else begin ph = PH_GAP; deadline = cyc + G; end
        end
      end
    endcase
    h3 = h2; h2 = h1; h1 = sw;
    s3 = s2; s2 = s1; s1 = ~start_n;
    lf = {lf[14:0], ^(lf & 16'hB400)};
  endtask

  task automatic compare_all();
    logic [NH-1:0] exp_led;
    exp_led = (ph == PH_UP) ? (NH'(1) << mole) : '0;
    chk("led",   32'(led),        32'(exp_led));
    chk("ones",  32'(score_ones), 32'(score % 10));
    chk("tens",  32'(score_tens), 32'(score / 10));
    chk("round", 32'(round_num),  32'(rnd));
    chk("hit",   32'(hit_pulse),  32'(x_hit));
    chk("miss",  32'(miss_pulse), 32'(x_miss));
    chk("over",  32'(game_over),  32'(ph == PH_OVER));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin model_reset(); cyc++; end
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic press_start();
    start_n = 1'b0;
    repeat (3) tick();
    start_n = 1'b1;
    tick();
  endtask

  task automatic wait_phase(input int target, input int budget);
    int n = 0;
    while (ph != target && n < budget) begin tick(); n++; end
    if (ph != target) chk("wait_phase_timeout", 32'(ph), 32'(target));
  endtask

  // kind: 0 lit only, 1 wrong only, 2 lit+wrong, 3 nothing (with an ignored start press)
  task automatic do_mole(input int off, input int kind);
    logic [NH-1:0] lit, wrong, m;
    lit   = NH'(1) << mole;
    wrong = NH'($urandom) & ~lit;
    if (wrong == '0) wrong = (mole == 0) ? NH'(2) : NH'(1);
    case (kind)
      0:       m = lit;
      1:       m = wrong;
      2:       m = lit | wrong;
      default: m = '0;
    endcase
    sw = '0;
    for (int t = 1; t <= M + 4 && ph == PH_UP; t++) begin
      tick();
      if (t == off) sw = m;
      if (t == off + 2) sw = '0;
      if (kind == 3 && t == 1) start_n = 1'b0;
      if (t == 3) start_n = 1'b1;
    end
    sw = '0;
    start_n = 1'b1;
  endtask

  function automatic logic [31:0] bcd(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  initial begin
    int n;
    cyc = 0;
    rst_n = 1'b0; start_n = 1'b1; start2_n = 1'b1; sw = '0; sw2 = '0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed opening game: hit, wrong-only miss, hit coinciding with the timeout cycle.
    press_start();
    wait_phase(PH_UP, 40);
    do_mole(1, 0);
    wait_phase(PH_UP, 40);
    do_mole(2, 1);
    wait_phase(PH_UP, 40);
    do_mole(M - 3, 2);
    wait_phase(PH_OVER, 40);

    repeat (6) begin sw = NH'($urandom); tick(); end
    sw = '0;
    repeat (3) tick();

    // Randomized games with button noise during the gaps.
    for (int g = 0; g < 6; g++) begin
      if (ph == PH_IDLE || ph == PH_OVER) press_start();
      for (int r = 0; r < 10 && ph != PH_OVER; r++) begin
        if ($urandom_range(0, 2) == 0) sw = NH'($urandom);
        wait_phase(PH_UP, 40);
        do_mole($urandom_range(1, M - 1), $urandom_range(0, 3));
      end
      wait_phase(PH_OVER, 40);
      repeat ($urandom_range(1, 5)) tick();
    end

    // Long game: score carries 09->10 and saturates at 99.
    start2_n = 1'b0;
    repeat (3) tick();
    start2_n = 1'b1;
    for (int h = 1; h <= 100; h++) begin
      n = 0;
      while (led2 == '0 && n < 40) begin tick(); n++; end
      if (led2 == '0) chk("long_mole_timeout", 32'(led2), 32'(1));
      sw2 = led2;
      n = 0;
      do begin tick(); n++; end while (!hit2 && n < 6);
      chk("long_hit", 32'(hit2), 32'(1));
      sw2 = '0;
      chk("long_score", 32'({tens2, ones2}), bcd(h < 99 ? h : 99));
    end
    repeat (2) tick();

    // Asynchronous reset while a mole is up.
    if (ph == PH_IDLE || ph == PH_OVER) press_start();
    wait_phase(PH_UP, 40);
    if (score == 0) begin
      do_mole(1, 0);
      wait_phase(PH_UP, 40);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("long_reset_score", 32'({tens2, ones2}), 32'(0));
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
    press_start();
    wait_phase(PH_UP, 40);
    do_mole(2, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
